// File: rtl/vec_mac_accum.sv
// vec_mac_accum: sequential multiply-accumulate back end.
// Sums up to 16 unsigned lane products and hands the result downstream.
module vec_mac_accum #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  vlen,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(16);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [CNT_W-1:0]   len_clamp;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ACC_W:0]     sum;

  assign len_clamp = (vlen > LEN_MAX) ? LEN_MAX : vlen;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  // One extra bit catches the carry out of the accumulator.
  assign sum = {1'b0, acc_q}
             + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len_clamp;
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len_clamp == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_d = sum[ACC_W-1:0];
          ovf_d = ovf_q | sum[ACC_W];
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state.
  always_comb begin
    in_ready_d  = (state_d == S_ACC);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_vec_mac_accum.sv
// tb_vec_mac_accum: scoreboard bench for vec_mac_accum.
// Expected sums are queued at start and checked when out_valid rises.
module tb_vec_mac_accum;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  vlen;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [ACC_W:0]    sb_q[$];
  logic [PROD_W-1:0] prod_tab[0:19];
  logic [31:0]       vpat;

  vec_mac_accum #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .vlen     (vlen),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .prod     (prod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: wrap modulo 2^ACC_W, sticky carry flag.
  function automatic logic [ACC_W:0] model(input int n);
    logic [ACC_W-1:0] a;
    logic [ACC_W:0]   s;
    logic             c;
    a = '0;
    c = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_tab[i]};
      a = s[ACC_W-1:0];
      c = c | s[ACC_W];
    end
    return {c, a};
  endfunction

  task automatic run_vec(input string tag, input int vl,
                         input bit nobub, input int stall,
                         input bit poke);
    int eff;
    int cyc;
    int idx;
    int rdy;
    logic [ACC_W:0]   e;
    logic [ACC_W-1:0] held;
    eff = (vl > 16) ? 16 : vl;
    sb_q.push_back(model(eff));
    start = 1'b1;
    vlen  = CNT_W'(vl);
    tick;
    start = 1'b0;
    cyc = 1;
    idx = 0;
    rdy = 0;
    while (!out_valid && cyc < 200) begin
      in_valid = vpat[(cyc - 1) % 32];
      prod     = prod_tab[idx % 20];
      if (in_ready) rdy++;
      if (in_ready && in_valid) idx++;
      if (poke && cyc == 2) begin
        start = 1'b1;
        vlen  = CNT_W'(1);
      end else begin
        start = 1'b0;
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_accepts"}, 64'(idx), 64'(eff));
    if (nobub) begin
      chk({tag, "_latency"}, 64'(cyc), 64'(eff + 1));
      chk({tag, "_rdy_cycles"}, 64'(rdy), 64'(eff));
    end
    held = acc_out;
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      start     = poke;
      vlen      = CNT_W'(2);
      tick;
      chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_stall_hold"}, 64'(acc_out), 64'(held));
    end
    out_ready = 1'b1;
    start     = poke;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_acc"}, 64'(acc_out), 64'(e[ACC_W-1:0]));
      chk({tag, "_ovf"}, 64'(ovf), 64'(e[ACC_W]));
    end
    chk({tag, "_busy_done"}, 64'(busy), 64'd1);
    tick;
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    tick;
    chk({tag, "_still_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    vlen      = '0;
    in_valid  = 1'b0;
    prod      = '0;
    out_ready = 1'b0;
    vpat      = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) prod_tab[i] = '0;
    tick;
    tick;
    chk("rst_acc", 64'(acc_out), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick;

    prod_tab[0] = 32'd15;
    prod_tab[1] = 32'h100;
    prod_tab[2] = 32'd1;
    prod_tab[3] = 32'hFFFF_FFFF;
    run_vec("v4", 4, 1'b1, 0, 1'b0);
    chk("v4_const", 64'(model(4)), 64'h01_0000_010F);

    for (int i = 0; i < 20; i++) prod_tab[i] = 32'hFFFE_0001;
    run_vec("v16", 16, 1'b1, 0, 1'b0);
    chk("v16_const", 64'(model(16)), 64'h0F_FFE0_0010);

    prod_tab[0] = 32'd7;
    prod_tab[1] = 32'd9;
    prod_tab[2] = 32'd11;
    vpat = 32'hFFFF_FFE9;
    run_vec("bub", 3, 1'b0, 3, 1'b0);
    chk("bub_const", 64'(model(3)), 64'd27);
    vpat = 32'hFFFF_FFFF;

    run_vec("v0", 0, 1'b1, 0, 1'b0);

    for (int i = 0; i < 20; i++) prod_tab[i] = PROD_W'(i * 1000 + 3);
    run_vec("v20", 20, 1'b1, 0, 1'b0);

    for (int i = 0; i < 20; i++) prod_tab[i] = PROD_W'($urandom);
    run_vec("poke", 5, 1'b1, 2, 1'b1);

    prod_tab[0] = 32'd100;
    prod_tab[1] = 32'd200;
    start = 1'b1;
    vlen  = CNT_W'(4);
    tick;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      prod     = prod_tab[i];
      tick;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mrst_acc", 64'(acc_out), 64'd0);
    chk("mrst_ovf", 64'(ovf), 64'd0);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_ready", 64'(in_ready), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    tick;
    chk("mrst_no_emit", 64'(out_valid), 64'd0);

    prod_tab[0] = 32'd5;
    run_vec("after_rst", 1, 1'b1, 0, 1'b0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vec_mac_accum.md
# vec_mac_accum

Sequential multiply-accumulate back end for the vector datapath. It consumes the stream of unsigned 32-bit lane products from the 16-bit Dadda multiplier stage, one product per handshake. It sums a programmable number of products, up to 16 lanes, into a wide accumulator. It then presents the dot-product result downstream through a valid/ready handshake.

## Interface
- PROD_W, 32, product width; matches the 16x16 multiplier output.
- ACC_W, 40, accumulator and result width; must be ≥ PROD_W+4.
- CNT_W, 5, vector-length field width (lengths 0..16).

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  input  1  begin a new accumulation; honoured only in IDLE.
- vlen  input  CNT_W  number of products to accumulate, sampled with start; values >16 are clamped to 16.
- in_valid  input  1  prod is valid.
- in_ready  output  1  block accepts prod this cycle.
- prod  input  PROD_W  unsigned product from the multiplier stage.
- out_valid  output  1  acc_out holds a completed result.
- out_ready  input  1  downstream accepts result.
- acc_out  output  ACC_W  accumulated sum, unsigned.
- ovf  output  1  set if any addition carried out of ACC_W in this accumulation.
- busy  output  1  high in ACC and DONE states.

## Operation
- FSM has three states: IDLE, ACC, DONE.
- IDLE
  - in_ready=0, out_valid=0, busy=0.
  - start=1: latch min(vlen,16) into len_q; clear acc, count and ovf.
  - Next state is ACC, or DONE if latched length is 0.
- ACC
  - in_ready=1, busy=1.
  - On in_valid&in_ready: acc ← acc + zero-extended prod, count ← count+1, ovf ← ovf | carry out of bit ACC_W-1.
  - When the accepted product makes count equal len_q, go to DONE on the same edge.
  - Cycles with in_valid=0 are bubbles: no state change.
- DONE
  - out_valid=1, busy=1, in_ready=0.
  - acc_out and ovf hold stable until out_ready=1; then go to IDLE.
- Arithmetic
  - Unsigned throughout; the sum wraps modulo 2^ACC_W.
  - With default widths ovf is unreachable (16·(2^32−1) < 2^40) but must still be implemented.
- start outside IDLE is ignored and does not disturb the current accumulation or result.
- prod is ignored whenever in_ready=0.
- acc_out always drives the acc register, and is qualified only by out_valid.

## Timing
- Reset (rst_n=0 at a clk edge) puts the block in this state: IDLE, acc_out=0, ovf=0, count=0, out_valid=0, in_ready=0, busy=0.
  - Reset takes priority over every other input, including mid-ACC and mid-DONE.
  - No partial result is emitted after reset.
- start sampled at edge T: in_ready=1 from cycle T+1.
- The last product is accepted at edge T+N (no bubbles): out_valid=1 from cycle T+N+1.
- Minimum latency from start to out_valid is N+1 cycles.
- out_valid&out_ready at edge E: IDLE from E+1. A start at E is ignored; start is honoured at E+1 at the earliest.
- Back-to-back throughput: N+2 cycles per vector with out_ready tied high.
- vlen=0: out_valid=1 with acc_out=0 one cycle after start.

## Test plan
- Reset, then start with vlen=4 and products 15, 0x100, 1, 0xFFFF_FFFF, no bubbles. Required:
  - in_ready=1 for exactly 4 cycles.
  - out_valid one cycle after the 4th accept.
  - acc_out=0x01_0000_010F, ovf=0.
- vlen=16 with every prod=0xFFFE_0001 (0xFFFF×0xFFFF). Required: acc_out=0x0F_FFE0_0010, ovf=0, out_valid after 17 cycles.
- Input bubbles and output backpressure. Stimulus:
  - vlen=3 with in_valid toggling 1,0,0,1,0,1 and prods 7, 9, 11.
  - out_ready held 0 for 3 cycles.
  - Required: acc_out=27, held stable with out_valid=1 across the stall; IDLE the cycle after out_ready=1.
- vlen=0, then vlen=20. Required:
  - vlen=0: out_valid next cycle with acc_out=0.
  - vlen=20: accepts exactly 16 products (clamp) before out_valid.
- start pulsed during ACC and during DONE. Required: ignored, and the running sum completes unchanged.
- rst_n=0 for one cycle after 2 of 4 products. Required:
  - All outputs return to reset values next cycle.
  - A following start with vlen=1, prod=5 yields acc_out=5.
